// File: rtl/run_ctrl.sv
// run_ctrl -- sequences one run of an attached SOC.
//
// The SOC is held in reset for RST_CYCLES cycles (HOLD). It is then released
// and allowed to execute (RUN) until it either halts or exceeds its cycle
// budget. A halt is a PC that stays unchanged for HALT_REPEAT consecutive
// valid samples (HALT). Running past the budget is a timeout (TOUT). Both end
// states are held until a restart request arrives, which starts a new HOLD.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-low reset
//   restart    in   single-cycle request to rerun the SOC
//   pc_valid   in   pc_i is meaningful this cycle
//   pc_i       in   SOC program counter [PC_W]
//   soc_rst    out  active-high reset to the SOC (high in HOLD)
//   running    out  high while in RUN
//   halted     out  sticky halt flag
//   timeout    out  sticky timeout flag
//   done       out  one-cycle pulse on entry to HALT or TOUT
//   cycle_cnt  out  RUN cycles of the current run [CNT_W]
//
// Every output is a flop; next values are computed from the next state, so
// no input reaches an output combinationally.

module run_ctrl #(
  parameter int RST_CYCLES  = 3,
  parameter int MAX_CYCLES  = 100,
  parameter int HALT_REPEAT = 4,
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             pc_valid,
  input  logic [PC_W-1:0]  pc_i,
  output logic             soc_rst,
  output logic             running,
  output logic             halted,
  output logic             timeout,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_TOUT = 2'd3
  } state_t;

  // The hold counter counts 0..RST_CYCLES-1; the edge leaving the last value
  // is the RST_CYCLES-th HOLD edge and moves to RUN.
  localparam logic [7:0]       HOLD_LAST = 8'(RST_CYCLES - 1);
  localparam logic [7:0]       REP_MAX   = 8'(HALT_REPEAT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  state_t           state_q,     state_d;
  logic [7:0]       hold_cnt_q,  hold_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [PC_W-1:0]  last_pc_q,   last_pc_d;
  logic [7:0]       rep_q,       rep_d;
  logic             halted_q,    halted_d;
  logic             timeout_q,   timeout_d;
  logic             done_q,      done_d;
  logic             soc_rst_q,   soc_rst_d;
  logic             running_q,   running_d;

  logic             go_hold_s;
  logic             halt_hit_s;
  logic             tout_hit_s;

  // Both end conditions look only at registered state, so when they coincide
  // the priority below (halt first) fully decides the outcome.
  assign halt_hit_s = (rep_q == REP_MAX);
  assign tout_hit_s = (cycle_cnt_q == CNT_LAST);

  // Next-state and next-output computation for the whole controller.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    last_pc_d   = last_pc_q;
    rep_d       = rep_q;
    halted_d    = halted_q;
    timeout_d   = timeout_q;
    done_d      = 1'b0;
    go_hold_s   = 1'b0;

    case (state_q)
      S_HOLD: begin
        if (restart) begin
          // Reload: HOLD lasts a full RST_CYCLES from this edge.
          hold_cnt_d = 8'd0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = S_RUN;
          hold_cnt_d = 8'd0;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end

      S_RUN: begin
        if (restart) begin
          // Abort without reporting: no done pulse, no flags.
          go_hold_s = 1'b1;
        end else begin
          if (cycle_cnt_q == CNT_SAT) begin
            cycle_cnt_d = cycle_cnt_q;
          end else begin
            cycle_cnt_d = cycle_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end

          // Repeat tracking: a changed PC restarts the run length at 1.
          if (pc_valid) begin
            if (pc_i == last_pc_q) begin
              rep_d = (rep_q == REP_MAX) ? rep_q : rep_q + 8'd1;
            end else begin
              last_pc_d = pc_i;
              rep_d     = 8'd1;
            end
          end else begin
            rep_d = rep_q;
          end

          if (halt_hit_s) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            done_d   = 1'b1;
          end else if (tout_hit_s) begin
            state_d   = S_TOUT;
            timeout_d = 1'b1;
            done_d    = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_HALT, S_TOUT: begin
        if (restart) begin
          go_hold_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        go_hold_s = 1'b1;
      end
    endcase

    // Every entry into HOLD starts a clean run.
    if (go_hold_s) begin
      state_d     = S_HOLD;
      hold_cnt_d  = 8'd0;
      cycle_cnt_d = {CNT_W{1'b0}};
      last_pc_d   = {PC_W{1'b0}};
      rep_d       = 8'd0;
      halted_d    = 1'b0;
      timeout_d   = 1'b0;
    end else begin
      hold_cnt_d = hold_cnt_d;
    end

    soc_rst_d = (state_d == S_HOLD);
    running_d = (state_d == S_RUN);
  end

  // State and output registers with asynchronous reset into HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_HOLD;
      hold_cnt_q  <= 8'd0;
      cycle_cnt_q <= {CNT_W{1'b0}};
      last_pc_q   <= {PC_W{1'b0}};
      rep_q       <= 8'd0;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
      soc_rst_q   <= 1'b1;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      last_pc_q   <= last_pc_d;
      rep_q       <= rep_d;
      halted_q    <= halted_d;
      timeout_q   <= timeout_d;
      done_q      <= done_d;
      soc_rst_q   <= soc_rst_d;
      running_q   <= running_d;
    end
  end

  assign soc_rst   = soc_rst_q;
  assign running   = running_q;
  assign halted    = halted_q;
  assign timeout   = timeout_q;
  assign done      = done_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Testbench for run_ctrl: randomized and directed stimulus; a queue-based
// scoreboard fed by a behavioural model of the run sequencing.

module tb_run_ctrl;

  localparam int RST_CYCLES  = 3;
  localparam int MAX_CYCLES  = 100;
  localparam int HALT_REPEAT = 4;

  logic        clk;
  logic        rst;
  logic        restart;
  logic        pc_valid;
  logic [31:0] pc_i;
  logic        soc_rst;
  logic        running;
  logic        halted;
  logic        timeout;
  logic        done;
  logic [31:0] cycle_cnt;

  int checks;
  int errors;

  run_ctrl #(
    .RST_CYCLES (RST_CYCLES),
    .MAX_CYCLES (MAX_CYCLES),
    .HALT_REPEAT(HALT_REPEAT),
    .PC_W       (32),
    .CNT_W      (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .pc_valid (pc_valid),
    .pc_i     (pc_i),
    .soc_rst  (soc_rst),
    .running  (running),
    .halted   (halted),
    .timeout  (timeout),
    .done     (done),
    .cycle_cnt(cycle_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  // Phase is described by flags: not running and no end flag means holding.
  int          m_hold_elapsed;
  bit          m_run;
  bit          m_halted;
  bit          m_tout;
  bit          m_done;
  longint      m_cnt;
  logic [31:0] m_samples[$];   // valid PC samples seen in this run

  logic [36:0] exp_q[$];

  function automatic int trailing_repeats();
    int n;
    n = 0;
    if (m_samples.size() > 0) begin
      for (int k = m_samples.size() - 1; k >= 0; k--) begin
        if (m_samples[k] == m_samples[m_samples.size() - 1]) n++;
        else break;
      end
    end
    return n;
  endfunction

  function automatic logic [36:0] model_outputs();
    logic [31:0] c;
    bit holding;
    c = m_cnt[31:0];
    holding = !m_run && !m_halted && !m_tout;
    return {holding, m_run, m_halted, m_tout, m_done, c};
  endfunction

  task automatic model_to_hold();
    m_run = 1'b0;
    m_halted = 1'b0;
    m_tout = 1'b0;
    m_cnt = 0;
    m_hold_elapsed = 0;
    m_samples.delete();
  endtask

  task automatic model_reset();
    model_to_hold();
    m_done = 1'b0;
  endtask

  // Drive one cycle of inputs (called just after a falling edge) and queue the
  // outputs the model predicts after the coming rising edge.
  task automatic step(input bit rs, input bit v, input logic [31:0] pc);
    bit halt_now;
    bit tout_now;
    restart  = rs;
    pc_valid = v;
    pc_i     = pc;
    m_done   = 1'b0;
    if (m_run) begin
      if (rs) begin
        model_to_hold();
      end else begin
        halt_now = (trailing_repeats() >= HALT_REPEAT);
        tout_now = (m_cnt == MAX_CYCLES - 1);
        if (m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt++;
        if (v) m_samples.push_back(pc);
        if (m_samples.size() > 256) void'(m_samples.pop_front());
        if (halt_now) begin
          m_run = 1'b0; m_halted = 1'b1; m_done = 1'b1;
        end else if (tout_now) begin
          m_run = 1'b0; m_tout = 1'b1; m_done = 1'b1;
        end
      end
    end else if (m_halted || m_tout) begin
      if (rs) model_to_hold();
    end else begin
      if (rs) begin
        m_hold_elapsed = 0;
      end else begin
        m_hold_elapsed++;
        if (m_hold_elapsed == RST_CYCLES) m_run = 1'b1;
      end
    end
    exp_q.push_back(model_outputs());
  endtask

  function automatic logic [36:0] dut_outputs();
    return {soc_rst, running, halted, timeout, done, cycle_cnt};
  endfunction

  task automatic compare(input string name, input logic [36:0] got, input logic [36:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got soc_rst=%b running=%b halted=%b timeout=%b done=%b cnt=%0d, want soc_rst=%b running=%b halted=%b timeout=%b done=%b cnt=%0d",
               name, $time, got[36], got[35], got[34], got[33], got[32], got[31:0],
               exp[36], exp[35], exp[34], exp[33], exp[32], exp[31:0]);
    end
  endtask

  // Monitor: after every rising edge, pop the prediction for that edge.
  initial begin
    logic [36:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare("cycle", dut_outputs(), e);
      end
    end
  end

  // Asynchronous reset pulse between clock edges; outputs must react at once.
  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    compare("async_reset", dut_outputs(), model_outputs());
    #1;
    rst = 1'b1;
  endtask

  logic [31:0] seq_halt [6] = '{32'd0, 32'd4, 32'd8, 32'd8, 32'd8, 32'd8};
  logic [31:0] prev_pc;
  logic [31:0] pc_n;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    restart = 1'b0;
    pc_valid = 1'b0;
    pc_i = 32'd0;
    prev_pc = 32'd0;
    model_reset();

    #12;
    compare("reset_state", dut_outputs(), model_outputs());

    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 32'd0);

    // Remaining HOLD edges after release, then the halting PC pattern.
    repeat (2) begin @(negedge clk); step(1'b0, 1'b0, 32'd0); end
    for (int i = 0; i < 6; i++) begin @(negedge clk); step(1'b0, 1'b1, seq_halt[i]); end
    for (int i = 0; i < 5; i++) begin @(negedge clk); step(1'b0, 1'b1, 32'd8); end

    // Restart from HALT, then a PC that never repeats -> timeout.
    @(negedge clk); step(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 110; i++) begin @(negedge clk); step(1'b0, 1'b1, 32'(i * 4 + 100)); end

    // Restart from TOUT; the repeat completes exactly on the last budget cycle.
    @(negedge clk); step(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      pc_n = (m_cnt >= 95) ? 32'd7777 : 32'(m_cnt * 4);
      step(1'b0, 1'b1, pc_n);
    end

    // Restart, run a little, then reset asynchronously mid-run.
    @(negedge clk); step(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 10; i++) begin @(negedge clk); step(1'b0, 1'b1, 32'(i + 50)); end
    pulse_reset();
    for (int i = 0; i < 10; i++) begin @(negedge clk); step(1'b0, 1'b1, 32'(i + 70)); end

    // Randomized phase: alternating epochs of repeat-heavy and incrementing PCs.
    for (int i = 0; i < 3000; i++) begin
      bit rs;
      bit v;
      if ($urandom_range(0, 499) == 0) pulse_reset();
      @(negedge clk);
      rs = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 3) != 0);
      if (((i / 250) % 2) == 1) pc_n = 32'(i);
      else if ($urandom_range(0, 1) == 1) pc_n = prev_pc;
      else pc_n = 32'($urandom_range(0, 7));
      prev_pc = pc_n;
      step(rs, v, pc_n);
    end

    @(negedge clk);
    restart = 1'b0;
    pc_valid = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 3: cycles soc_rst is held asserted after reset release or restart; legal range 1..255.
REQ-002 Parameter MAX_CYCLES, default 100: RUN-state cycle budget before timeout; legal range 1..2^CNT_W-1.
REQ-003 Parameter HALT_REPEAT, default 4: consecutive valid samples of an unchanged PC that declare a halt; legal range 2..255.
REQ-004 Parameter PC_W, default 32: PC width.
REQ-005 Parameter CNT_W, default 32: cycle counter width.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 restart  input  1  single-cycle request to rerun the SOC.
REQ-009 pc_valid  input  1  pc_i is meaningful this cycle.
REQ-010 pc_i  input  PC_W  SOC program counter.
REQ-011 soc_rst  output  1  reset to the SOC, active-high (1 = `ENABLE).
REQ-012 running  output  1  high in RUN.
REQ-013 halted  output  1  sticky halt flag.
REQ-014 timeout  output  1  sticky timeout flag.
REQ-015 done  output  1  one-cycle pulse on entry to HALT or TOUT.
REQ-016 cycle_cnt  output  CNT_W  cycles spent in RUN for the current run.

Function
REQ-017 States SHALL be HOLD, RUN, HALT and TOUT; the state SHALL be registered.
REQ-018 In HOLD, soc_rst=1 and a hold counter increments each cycle. After exactly RST_CYCLES HOLD cycles, the state SHALL go to RUN and soc_rst SHALL drop on the same edge.
REQ-019 In RUN, cycle_cnt SHALL increment by 1 each cycle, saturating at all-ones. cycle_cnt SHALL be cleared to 0 on entry to HOLD.
REQ-020 Halt detection, in RUN only:
- Registers last_pc and a repeat counter rep.
- On pc_valid with pc_i==last_pc: rep increments, saturating at HALT_REPEAT.
- On pc_valid with pc_i!=last_pc: last_pc<=pc_i and rep<=1.
- When pc_valid is low: hold both.
REQ-021 When rep reaches HALT_REPEAT, the next edge SHALL set state=HALT and halted=1, and emit done for 1 cycle.
REQ-022 When cycle_cnt==MAX_CYCLES-1 in RUN and no halt is declared that cycle, the next edge SHALL set state=TOUT and timeout=1, and emit done for 1 cycle.
REQ-023 If halt and timeout conditions occur in the same cycle, halt SHALL win: only halted is set.
REQ-024 In HALT and TOUT, cycle_cnt freezes, soc_rst=0, running=0, and the state holds until restart.
REQ-025 restart in HALT or TOUT SHALL clear halted, timeout, cycle_cnt, the hold counter, last_pc and rep, and enter HOLD next edge.
REQ-026 restart in RUN SHALL abort the run and enter HOLD next edge; done SHALL NOT pulse.
REQ-027 restart in HOLD SHALL reload the hold counter, extending HOLD to RST_CYCLES from that edge.
REQ-028 All outputs SHALL be driven directly from registers, with no combinational input-to-output paths.

Reset
REQ-029 rst=0 SHALL immediately, without waiting for clk, force:
- state=HOLD, soc_rst=1
- running=0, halted=0, timeout=0, done=0
- cycle_cnt=0, hold counter=0, last_pc=0, rep=0
REQ-030 Reset asserted mid-run SHALL discard all state. After rst returns to 1, sequencing SHALL restart from the beginning of HOLD.
REQ-031 Release of rst SHALL be treated as synchronous to clk; the first HOLD count SHALL occur on the first rising edge with rst=1.

Verification
REQ-032 Defaults, rst low 30ns then high (10ns clk) -> soc_rst=1 for exactly 3 edges after release, then running=1.
REQ-033 PC sequence 0,4,8,8,8,8 with pc_valid=1 -> halted=1 and done pulses 1 cycle on the edge after the fourth 8; cycle_cnt then freezes.
REQ-034 PC increments forever -> on the 100th RUN edge: timeout=1, done pulses, cycle_cnt=100, halted=0.
REQ-035 MAX_CYCLES=6 with the halt repeat completing on cycle 5 -> halted=1, timeout=0.
REQ-036 restart after TOUT -> flags clear, soc_rst=1 for 3 cycles, cycle_cnt restarts at 0.
REQ-037 rst pulsed low mid-RUN between clock edges -> soc_rst=1 and running=0 immediately; then a full HOLD sequence follows.
